// File: rtl/addsub_vector_checker.sv
// Stimulus/response engine for an N-bit adder-subtractor: three directed corner
// vectors followed by LFSR-derived vectors, each checked against a reference model.
module addsub_vector_checker #(
  parameter int          N           = 8,
  parameter int          NUM_VECTORS = 16,
  parameter int          SETTLE      = 1,
  parameter logic [31:0] SEED        = 32'hACE1_2024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] A_out,
  output logic [N-1:0] B_out,
  output logic         Op_out,
  input  logic [N-1:0] S_in,
  input  logic         Cout_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   err_count,
  output logic [7:0]   vec_idx
);

  localparam logic [31:0]   SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam int            CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [7:0]    LAST_IDX    = 8'(NUM_VECTORS - 1);
  localparam logic [N-1:0]  ALL_ONES    = {N{1'b1}};
  localparam logic [N-1:0]  LSB_ONLY    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  MSB_ONLY    = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r;
  logic [31:0]   lfsr_r;
  logic [CW-1:0] cnt_r;
  logic [N:0]    expected_r;

  logic          launch_s;
  logic [7:0]    gen_idx_s;
  logic [31:0]   lfsr_base_s;
  logic [31:0]   lfsr_step_s;
  logic [31:0]   lfsr_gen_s;
  logic [N-1:0]  gen_a_s;
  logic [N-1:0]  gen_b_s;
  logic          gen_op_s;
  logic [N:0]    gen_exp_s;
  logic          mismatch_s;
  logic [7:0]    err_next_s;

  // Fibonacci LFSR, taps 32,22,2,1, shifting towards the MSB.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  function automatic logic [N:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic op);
    logic [N:0] r;
    if (op) begin
      r = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  // Next vector to present (vector 0 on launch, else vec_idx+1) and the error update.
  always_comb begin
    launch_s    = 1'b0;
    gen_idx_s   = 8'd0;
    lfsr_base_s = SEED_EFF;
    lfsr_gen_s  = SEED_EFF;
    gen_a_s     = {N{1'b0}};
    gen_b_s     = {N{1'b0}};
    gen_op_s    = 1'b0;
    if ((state_r == IDLE || state_r == DONE) && start) begin
      launch_s = 1'b1;
    end else begin
      launch_s = 1'b0;
    end
    if (launch_s) begin
      gen_idx_s   = 8'd0;
      lfsr_base_s = SEED_EFF;
    end else begin
      gen_idx_s   = vec_idx + 8'd1;
      lfsr_base_s = lfsr_r;
    end
    lfsr_step_s = lfsr_advance(lfsr_base_s);
    if (gen_idx_s >= 8'd3) begin
      lfsr_gen_s = lfsr_step_s;
    end else begin
      lfsr_gen_s = lfsr_base_s;
    end
    case (gen_idx_s)
      8'd0: begin
        gen_a_s  = ALL_ONES;
        gen_b_s  = LSB_ONLY;
        gen_op_s = 1'b0;
      end
      8'd1: begin
        gen_a_s  = {N{1'b0}};
        gen_b_s  = LSB_ONLY;
        gen_op_s = 1'b1;
      end
      8'd2: begin
        gen_a_s  = MSB_ONLY;
        gen_b_s  = MSB_ONLY;
        gen_op_s = 1'b1;
      end
      default: begin
        gen_a_s  = lfsr_gen_s[N-1:0];
        gen_b_s  = lfsr_gen_s[2*N-1:N];
        gen_op_s = lfsr_gen_s[31];
      end
    endcase
    gen_exp_s  = ref_result(gen_a_s, gen_b_s, gen_op_s);
    mismatch_s = ({Cout_in, S_in} != expected_r);
    if (mismatch_s && (err_count != 8'hFF)) begin
      err_next_s = err_count + 8'd1;
    end else begin
      err_next_s = err_count;
    end
  end

  // Run sequencer: every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      lfsr_r     <= SEED_EFF;
      cnt_r      <= {CW{1'b0}};
      expected_r <= {(N+1){1'b0}};
      A_out      <= {N{1'b0}};
      B_out      <= {N{1'b0}};
      Op_out     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      vec_idx    <= 8'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (launch_s) begin
            err_count  <= 8'd0;
            vec_idx    <= 8'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            lfsr_r     <= lfsr_gen_s;
            A_out      <= gen_a_s;
            B_out      <= gen_b_s;
            Op_out     <= gen_op_s;
            expected_r <= gen_exp_s;
            cnt_r      <= {CW{1'b0}};
            state_r    <= DRIVE;
          end else begin
            state_r <= state_r;
          end
        end
        DRIVE: begin
          if (cnt_r == SETTLE_LAST) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= CHECK;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        CHECK: begin
          err_count <= err_next_s;
          if (vec_idx == LAST_IDX) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next_s == 8'd0);
            state_r <= DONE;
          end else begin
            vec_idx    <= gen_idx_s;
            lfsr_r     <= lfsr_gen_s;
            A_out      <= gen_a_s;
            B_out      <= gen_b_s;
            Op_out     <= gen_op_s;
            expected_r <= gen_exp_s;
            state_r    <= DRIVE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_vector_checker.sv
// Scoreboard bench for addsub_vector_checker: expected vectors and run results are
// queued at stimulus time and popped by monitors as the checker presents them.
module tb_addsub_vector_checker;

  localparam int          NV   = 16;
  localparam logic [31:0] SEED = 32'hACE1_2024;

  typedef struct {
    int done_cyc;
    int err;
    int kind;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] a1, b1, s1, err1, idx1;
  logic [7:0] a3, b3, s3, err3, idx3;
  logic       op1, c1, busy1, done1, pass1;
  logic       op3, c3, busy3, done3, pass3;
  logic [8:0] d1a, d1b, d3a, d3b;
  int         mode = 0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  res_t       rq1[$];
  res_t       rq3[$];
  vec_t       vq1[$];
  vec_t       ve1;
  res_t       re1, re3;
  logic       prev_busy1 = 1'b0;
  logic       prev_done1 = 1'b0;
  logic       prev_done3 = 1'b0;
  logic [7:0] prev_idx1 = 8'd0;
  int         st, cc, dummy;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  addsub_vector_checker #(.N(8), .NUM_VECTORS(NV), .SETTLE(1), .SEED(SEED)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .A_out(a1), .B_out(b1), .Op_out(op1), .S_in(s1), .Cout_in(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_idx(idx1)
  );

  addsub_vector_checker #(.N(8), .NUM_VECTORS(NV), .SETTLE(3), .SEED(SEED)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .A_out(a3), .B_out(b3), .Op_out(op3), .S_in(s3), .Cout_in(c3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .vec_idx(idx3)
  );

  // Bit-serial ripple adder-subtractor used as the unit under test.
  function automatic logic [8:0] golden(input logic [7:0] a, input logic [7:0] b, input logic op);
    logic       c;
    logic       bi;
    logic [7:0] s;
    c = op;
    for (int i = 0; i < 8; i++) begin
      bi   = b[i] ^ op;
      s[i] = a[i] ^ bi ^ c;
      c    = (a[i] & bi) | (c & (a[i] ^ bi));
    end
    return {c, s};
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  always @(posedge clk) begin
    d1a <= golden(a1, b1, op1);
    d1b <= d1a;
    d3a <= golden(a3, b3, op3);
    d3b <= d3a;
  end

  always_comb begin
    {c1, s1} = golden(a1, b1, op1);
    case (mode)
      1: if (idx1 == 8'd5) s1[0] = ~s1[0];
      2: c1 = 1'b0;
      3: {c1, s1} = d1b;
      default: ;
    endcase
  end

  assign {c3, s3} = d3b;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the full expected vector list for one run; returns how many expect Cout=1.
  task automatic build_run(output int couts);
    logic [31:0] lf;
    vec_t        v;
    logic [8:0]  g;
    lf    = SEED;
    couts = 0;
    for (int i = 0; i < NV; i++) begin
      if (i == 0)      v = '{8'hFF, 8'h01, 1'b0};
      else if (i == 1) v = '{8'h00, 8'h01, 1'b1};
      else if (i == 2) v = '{8'h80, 8'h80, 1'b1};
      else begin
        lf   = lfsr_step(lf);
        v.a  = lf[7:0];
        v.b  = lf[15:8];
        v.op = lf[31];
      end
      g = golden(v.a, v.b, v.op);
      if (g[8]) couts++;
      vq1.push_back(v);
    end
  endtask

  task automatic pulse1(output int start_cyc);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start1 = 1'b0;
  endtask

  task automatic pulse3(output int start_cyc);
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start3 = 1'b0;
  endtask

  task automatic wait_done1(input int limit);
    int n = 0;
    while (!done1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done1) check("done1_timeout", 0, 1);
  endtask

  task automatic wait_done3(input int limit);
    int n = 0;
    while (!done3 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done3) check("done3_timeout", 0, 1);
  endtask

  task automatic wait_idx1(input logic [7:0] v, input int limit);
    int n = 0;
    while (idx1 != v && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (idx1 != v) check("idx1_timeout", idx1, v);
  endtask

  // Monitor for the SETTLE=1 checker: vector on every new index, result on done rise.
  always @(negedge clk) begin
    if (busy1 && (!prev_busy1 || idx1 != prev_idx1)) begin
      if (vq1.size() == 0) begin
        check("vec_unexpected", 1, 0);
      end else begin
        ve1 = vq1.pop_front();
        check("A_out", a1, ve1.a);
        check("B_out", b1, ve1.b);
        check("Op_out", op1, ve1.op);
      end
    end
    if (done1 && !prev_done1) begin
      if (rq1.size() == 0) begin
        check("done1_unexpected", 1, 0);
      end else begin
        re1 = rq1.pop_front();
        check("done1_cycle", cyc, re1.done_cyc);
        check("busy1_at_done", busy1, 0);
        if (re1.kind == 0) begin
          check("err1_count", err1, re1.err);
          check("pass1", pass1, (re1.err == 0) ? 1 : 0);
        end else begin
          check("err1_nonzero", (err1 > 0) ? 1 : 0, 1);
          check("pass1_low", pass1, 0);
        end
      end
    end
    prev_busy1 <= busy1;
    prev_idx1  <= idx1;
    prev_done1 <= done1;
  end

  // Result monitor for the SETTLE=3 checker.
  always @(negedge clk) begin
    if (done3 && !prev_done3) begin
      if (rq3.size() == 0) begin
        check("done3_unexpected", 1, 0);
      end else begin
        re3 = rq3.pop_front();
        check("done3_cycle", cyc, re3.done_cyc);
        check("err3_count", err3, re3.err);
        check("pass3", pass3, 1);
        check("idx3_last", idx3, NV - 1);
        check("busy3_at_done", busy3, 0);
      end
    end
    prev_done3 <= done3;
  end

  initial begin
    // Reset asserted between clock edges must clear outputs without a clock.
    #2 rst = 1'b1;
    #1;
    check("rst_A", a1, 0);
    check("rst_B", b1, 0);
    check("rst_Op", op1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_err", err1, 0);
    check("rst_idx", idx1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy1, 0);
    check("idle_done", done1, 0);

    // Golden unit, single run.
    mode = 0;
    build_run(cc);
    pulse1(st);
    rq1.push_back('{st + 2 * NV, 0, 0});
    wait_done1(100);

    // Single flipped bit on vector 5, then Cout tied low (restarted from DONE).
    mode = 1;
    build_run(cc);
    pulse1(st);
    rq1.push_back('{st + 2 * NV, 1, 0});
    wait_done1(100);
    mode = 2;
    build_run(cc);
    pulse1(st);
    check("clr_err", err1, 0);
    check("clr_done", done1, 0);
    check("clr_pass", pass1, 0);
    check("clr_idx", idx1, 0);
    rq1.push_back('{st + 2 * NV, cc, 0});
    wait_done1(100);

    // start while busy is ignored; start in DONE replays the sequence.
    mode = 0;
    build_run(cc);
    pulse1(st);
    rq1.push_back('{st + 2 * NV, 0, 0});
    wait_idx1(8'd4, 50);
    pulse1(dummy);
    wait_done1(100);
    build_run(cc);
    pulse1(st);
    rq1.push_back('{st + 2 * NV, 0, 0});
    wait_done1(100);

    // Reset during DRIVE of vector 3, then a fresh run from v0.
    build_run(cc);
    pulse1(st);
    rq1.push_back('{st + 2 * NV, 0, 0});
    wait_idx1(8'd3, 50);
    #2 rst = 1'b1;
    vq1.delete();
    rq1.delete();
    #1;
    check("midrst_A", a1, 0);
    check("midrst_B", b1, 0);
    check("midrst_Op", op1, 0);
    check("midrst_busy", busy1, 0);
    check("midrst_idx", idx1, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_busy", busy1, 0);
    build_run(cc);
    pulse1(st);
    rq1.push_back('{st + 2 * NV, 0, 0});
    wait_done1(100);

    // Unit with a 2-cycle output delay: SETTLE=3 passes, SETTLE=1 catches it early.
    pulse3(st);
    rq3.push_back('{st + 4 * NV, 0, 0});
    wait_done3(200);
    mode = 3;
    build_run(cc);
    pulse1(st);
    rq1.push_back('{st + 2 * NV, 0, 1});
    wait_done1(100);

    repeat (2) @(negedge clk);
    check("rq1_drained", rq1.size(), 0);
    check("rq3_drained", rq3.size(), 0);
    check("vq1_drained", vq1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
